// File: rtl/uart_pkg.sv
// Shared ASCII constants, FSM state encoding and byte-class helpers for the UART command parser.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package uart_pkg;

    localparam logic [7:0] CH_HASH  = 8'h23;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CASE_BIT = 8'h20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MODE = 2'd1,
        ARG  = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

    function automatic logic is_term(input logic [7:0] c);
        return (c == CH_CR) || (c == CH_LF);
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Idle-cycle counter: clear restarts the count, expire flags TIMEOUT_CYC-1 idle cycles while enabled.
// Latency: expire is combinational from the count register; clear takes effect next cycle.
// Backpressure: none; counter saturates at the expiry value until cleared or disabled.
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    // Count idle cycles while enabled; any received byte or leaving the frame restarts from zero.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A byte arriving on the expiry cycle takes priority over the abort.
    assign expire = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses "#<mode>[digits]<CR|LF>" frames into a one-hot mode enable plus a saturating numeric parameter.
// Latency: outputs and cmd_done update 1 cycle after the terminator strobe; cmd_err 1 cycle after the offending byte or timeout.
// Backpressure: none; every valid_flag byte is consumed in the cycle it is presented.
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter int N_MODE      = 2,
    parameter int PARAM_W     = 8,
    parameter int PARAM_MAX   = 255,
    parameter int PARAM_RST   = 0,
    parameter int MAX_DIGITS  = 3,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic                            sys_clk,
    input  logic                            rst,
    input  logic [7:0]                      rx_data,
    input  logic                            valid_flag,
    output logic [N_MODE-1:0]               mode_en,
    output logic [$clog2(N_MODE+1)-1:0]     mode_idx,
    output logic [PARAM_W-1:0]              param,
    output logic                            cmd_done,
    output logic                            cmd_err
);

    localparam int IW = $clog2(N_MODE + 1);
    localparam int AW = PARAM_W + 4;
    localparam int DW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS + 1) : 1;

    state_t          state;
    logic [IW-1:0]   pend_idx;
    logic [AW-1:0]   acc;
    logic [DW-1:0]   dcnt;
    logic            tmo_expire;

    logic [7:0]      up_ch;
    logic            letter_ok;
    logic            zero_ok;
    logic [IW-1:0]   letter_idx;
    logic [AW-1:0]   acc_mul;
    logic [AW-1:0]   acc_sat;
    logic [N_MODE-1:0] pend_onehot;

    // Classify the incoming byte: fold lower case onto upper case and decode the mode letter.
    always_comb begin
        up_ch      = rx_data & ~CASE_BIT;
        letter_ok  = (up_ch >= CH_A) && (up_ch < (CH_A + 8'(N_MODE)));
        zero_ok    = (rx_data == CH_0);
        letter_idx = IW'(up_ch - CH_A + 8'd1);
    end

    // Next decimal accumulator value; acc never exceeds PARAM_MAX so acc*10+9 fits in AW bits.
    always_comb begin
        acc_mul = (acc * AW'(10)) + AW'(rx_data[3:0]);
        acc_sat = (acc_mul > AW'(PARAM_MAX)) ? AW'(PARAM_MAX) : acc_mul;
    end

    // One-hot decode of the pending mode; index 0 means all modes off.
    always_comb begin
        pend_onehot = '0;
        for (int k = 1; k <= N_MODE; k++) begin
            if (pend_idx == IW'(k)) begin
                pend_onehot[k-1] = 1'b1;
            end
        end
    end

    uart_cmd_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .sys_clk (sys_clk),
        .rst     (rst),
        .en      (state != IDLE),
        .clr     (valid_flag),
        .expire  (tmo_expire)
    );

    // Frame FSM with registered outputs; a received byte always wins over a timeout in the same cycle.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pend_idx <= '0;
            acc      <= '0;
            dcnt     <= '0;
            mode_en  <= '0;
            mode_idx <= '0;
            param    <= PARAM_W'(PARAM_RST);
            cmd_done <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            cmd_done <= 1'b0;
            cmd_err  <= 1'b0;
            if (valid_flag) begin
                case (state)
                    IDLE: begin
                        if (rx_data == CH_HASH) begin
                            state <= MODE;
                        end
                    end
                    MODE: begin
                        if (letter_ok || zero_ok) begin
                            pend_idx <= letter_ok ? letter_idx : '0;
                            acc      <= '0;
                            dcnt     <= '0;
                            state    <= ARG;
                        end else if (rx_data == CH_HASH) begin
                            cmd_err <= 1'b1;
                        end else begin
                            cmd_err <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                    ARG: begin
                        if (is_digit(rx_data)) begin
                            if (dcnt == DW'(MAX_DIGITS)) begin
                                cmd_err <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                acc  <= acc_sat;
                                dcnt <= dcnt + 1'b1;
                            end
                        end else if (is_term(rx_data)) begin
                            mode_en  <= pend_onehot;
                            mode_idx <= pend_idx;
                            if (dcnt != '0) begin
                                param <= acc[PARAM_W-1:0];
                            end
                            cmd_done <= 1'b1;
                            state    <= IDLE;
                        end else if (rx_data == CH_HASH) begin
                            cmd_err <= 1'b1;
                            state   <= MODE;
                        end else begin
                            cmd_err <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end else if (tmo_expire) begin
                cmd_err <= 1'b1;
                state   <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser (N_MODE=2, PARAM_MAX=200, TIMEOUT_CYC=100).
// Expected done/err events are queued with their due cycle and matched by a negedge monitor.
// Each scenario task also checks that outputs hold and that no expected event went missing.
module tb_uart_cmd_parser;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       valid_flag = 1'b0;
    logic [1:0] mode_en;
    logic [1:0] mode_idx;
    logic [7:0] param;
    logic       cmd_done;
    logic       cmd_err;

    uart_cmd_parser #(
        .N_MODE      (2),
        .PARAM_W     (8),
        .PARAM_MAX   (200),
        .PARAM_RST   (0),
        .MAX_DIGITS  (3),
        .TIMEOUT_CYC (100)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .valid_flag (valid_flag),
        .mode_en    (mode_en),
        .mode_idx   (mode_idx),
        .param      (param),
        .cmd_done   (cmd_done),
        .cmd_err    (cmd_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit         is_err;
        logic [1:0] en;
        logic [1:0] idx;
        logic [7:0] prm;
        int         at_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    // Model of the outputs the DUT must currently hold.
    logic [1:0] m_en = 2'b00;
    logic [1:0] m_idx = 2'd0;
    logic [7:0] m_param = 8'd0;

    always @(posedge sys_clk) cyc++;

    // Scoreboard monitor: every done/err pulse must match the oldest queued expectation.
    always @(negedge sys_clk) begin
        if (!rst && (cmd_done || cmd_err)) begin
            exp_t e;
            n_tests++;
            if (cmd_done && cmd_err) begin
                n_fail++;
                $display("FAIL both_pulses: cmd_done=1 cmd_err=1 at cycle %0d, required mutually exclusive", cyc);
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: done=%0b err=%0b at cycle %0d, required no event", cmd_done, cmd_err, cyc);
            end else begin
                e = exp_q.pop_front();
                if (cmd_err !== e.is_err || cyc != e.at_cyc || mode_en !== e.en ||
                    mode_idx !== e.idx || param !== e.prm) begin
                    n_fail++;
                    $display("FAIL event: got err=%0b cyc=%0d en=%b idx=%0d param=%0d, required err=%0b cyc=%0d en=%b idx=%0d param=%0d",
                             cmd_err, cyc, mode_en, mode_idx, param,
                             e.is_err, e.at_cyc, e.en, e.idx, e.prm);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data    = b;
        valid_flag = 1'b1;
        @(negedge sys_clk);
        valid_flag = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
    endtask

    task automatic expect_done(input logic [1:0] en, input logic [1:0] idx, input logic [7:0] prm);
        exp_t e;
        e = '{is_err: 1'b0, en: en, idx: idx, prm: prm, at_cyc: cyc + 1};
        exp_q.push_back(e);
        m_en = en;
        m_idx = idx;
        m_param = prm;
    endtask

    task automatic expect_err(input int lat);
        exp_t e;
        e = '{is_err: 1'b1, en: m_en, idx: m_idx, prm: m_param, at_cyc: cyc + lat};
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        n_tests++;
        if (mode_en !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mode_en: got %b, required 00", mode_en);
        end
        n_tests++;
        if (mode_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mode_idx: got %0d, required 0", mode_idx);
        end
        n_tests++;
        if (param !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_param: got %0d, required 0", param);
        end
        n_tests++;
        if ({cmd_done, cmd_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_pulses: got done=%0b err=%0b, required 0 0", cmd_done, cmd_err);
        end
        rst = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_basic;
        send_str("#B");
        expect_done(2'b10, 2'd2, 8'd0);
        send_byte(8'h0D);
        repeat (3) @(negedge sys_clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_pending: got %0d missing events, required 0", exp_q.size());
            exp_q.delete();
        end
        n_tests++;
        if ({mode_en, mode_idx, param} !== {m_en, m_idx, m_param}) begin
            n_fail++;
            $display("FAIL basic_hold: got en=%b idx=%0d param=%0d, required en=%b idx=%0d param=%0d",
                     mode_en, mode_idx, param, m_en, m_idx, m_param);
        end
    endtask

    task automatic test_arg;
        send_str("#a128");
        expect_done(2'b01, 2'd1, 8'd128);
        send_byte(8'h0A);
        send_str("#0");
        expect_done(2'b00, 2'd0, 8'd128);
        send_byte(8'h0D);
        repeat (3) @(negedge sys_clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL arg_pending: got %0d missing events, required 0", exp_q.size());
            exp_q.delete();
        end
        n_tests++;
        if ({mode_en, mode_idx, param} !== {m_en, m_idx, m_param}) begin
            n_fail++;
            $display("FAIL arg_hold: got en=%b idx=%0d param=%0d, required en=%b idx=%0d param=%0d",
                     mode_en, mode_idx, param, m_en, m_idx, m_param);
        end
    endtask

    task automatic test_saturate;
        send_str("#a999");
        expect_done(2'b01, 2'd1, 8'd200);
        send_byte(8'h0D);
        send_str("#a123");
        expect_err(1);
        send_byte("4");
        send_byte(8'h0D);
        repeat (3) @(negedge sys_clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL saturate_pending: got %0d missing events, required 0", exp_q.size());
            exp_q.delete();
        end
        n_tests++;
        if ({mode_en, mode_idx, param} !== {2'b01, 2'd1, 8'd200}) begin
            n_fail++;
            $display("FAIL saturate_hold: got en=%b idx=%0d param=%0d, required en=01 idx=1 param=200",
                     mode_en, mode_idx, param);
        end
    endtask

    task automatic test_errors;
        send_byte("#");
        expect_err(1);
        send_byte("Z");
        send_byte(8'h0D);
        send_str("#b1");
        expect_err(1);
        send_byte("x");
        send_byte(8'h0D);
        send_byte("#");
        expect_err(1);
        send_byte("c");
        send_byte(8'h0A);
        repeat (2) @(negedge sys_clk);
        n_tests++;
        if ({mode_en, mode_idx, param} !== {2'b01, 2'd1, 8'd200}) begin
            n_fail++;
            $display("FAIL errors_hold: got en=%b idx=%0d param=%0d, required en=01 idx=1 param=200",
                     mode_en, mode_idx, param);
        end
        send_str("#b");
        expect_err(1);
        send_byte("#");
        send_str("a5");
        expect_done(2'b01, 2'd1, 8'd5);
        send_byte(8'h0D);
        send_byte("#");
        expect_err(1);
        send_byte("#");
        send_str("B7");
        expect_done(2'b10, 2'd2, 8'd7);
        send_byte(8'h0D);
        repeat (3) @(negedge sys_clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL errors_pending: got %0d missing events, required 0", exp_q.size());
            exp_q.delete();
        end
        n_tests++;
        if ({mode_en, mode_idx, param} !== {m_en, m_idx, m_param}) begin
            n_fail++;
            $display("FAIL errors_final: got en=%b idx=%0d param=%0d, required en=%b idx=%0d param=%0d",
                     mode_en, mode_idx, param, m_en, m_idx, m_param);
        end
    endtask

    task automatic test_timeout;
        send_byte("#");
        // 'B' is sampled one cycle from now; the abort lands 100 cycles after that.
        expect_err(101);
        send_byte("B");
        repeat (110) @(negedge sys_clk);
        send_byte(8'h0D);
        repeat (3) @(negedge sys_clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_pending: got %0d missing events, required 0", exp_q.size());
            exp_q.delete();
        end
        n_tests++;
        if ({mode_en, mode_idx, param} !== {2'b10, 2'd2, 8'd7}) begin
            n_fail++;
            $display("FAIL timeout_hold: got en=%b idx=%0d param=%0d, required en=10 idx=2 param=7",
                     mode_en, mode_idx, param);
        end
        send_str("#B");
        repeat (99) @(negedge sys_clk);
        send_byte("5");
        expect_done(2'b10, 2'd2, 8'd5);
        send_byte(8'h0D);
        repeat (3) @(negedge sys_clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_race_pending: got %0d missing events, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back;
        send_str("#a7");
        expect_done(2'b01, 2'd1, 8'd7);
        send_byte(8'h0D);
        send_str("#B15");
        expect_done(2'b10, 2'd2, 8'd15);
        send_byte(8'h0A);
        repeat (3) @(negedge sys_clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_pending: got %0d missing events, required 0", exp_q.size());
            exp_q.delete();
        end
        n_tests++;
        if ({mode_en, mode_idx, param} !== {2'b10, 2'd2, 8'd15}) begin
            n_fail++;
            $display("FAIL b2b_hold: got en=%b idx=%0d param=%0d, required en=10 idx=2 param=15",
                     mode_en, mode_idx, param);
        end
    endtask

    task automatic test_reset_midframe;
        send_str("#b12");
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({mode_en, mode_idx, param, cmd_done, cmd_err} !== {2'b00, 2'd0, 8'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got en=%b idx=%0d param=%0d done=%0b err=%0b, required all zero",
                     mode_en, mode_idx, param, cmd_done, cmd_err);
        end
        @(negedge sys_clk);
        rst = 1'b0;
        m_en = 2'b00;
        m_idx = 2'd0;
        m_param = 8'd0;
        send_byte(8'h0D);
        repeat (3) @(negedge sys_clk);
        n_tests++;
        if ({mode_en, mode_idx, param} !== {m_en, m_idx, m_param}) begin
            n_fail++;
            $display("FAIL reset_discard: got en=%b idx=%0d param=%0d, required en=00 idx=0 param=0",
                     mode_en, mode_idx, param);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_arg;
        test_saturate;
        test_errors;
        test_timeout;
        test_back_to_back;
        test_reset_midframe;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
